// File: rtl/apb_slave_regs.sv
// rtl/apb_slave_regs.sv - APB slave register bank with transfer counters; optional protocol checker under APB_SLV_PROT_CHK_EN
module apb_slave_regs #(
    parameter int DEPTH   = 16,
    parameter int SEL_IDX = 0
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [2:0]  pselx,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count,
    output logic        prot_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            sel;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   lat_idx;
    logic            lat_wr;
    logic            setup_go;
    logic            xfer_done;
    logic [31:0]     mem [DEPTH];

    assign sel = pselx[SEL_IDX];
    assign idx = paddr[AW+1:2];

    // Address bits outside the index and the other select lines are deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{paddr[31:AW+2], paddr[1:0], pselx};

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        setup_go  = 1'b0;
        case (state)
            IDLE: begin
                if (sel && !penable) begin
                    state_nxt = SETUP;
                    setup_go  = 1'b1;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (sel && !penable) begin
                    state_nxt = SETUP;
                    setup_go  = 1'b1;
                end else if (!sel) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef APB_SLV_PROT_CHK_EN
    logic viol;

    always_comb begin
        viol = 1'b0;
        case (state)
            IDLE:    viol = sel && penable;
            SETUP:   viol = !sel || !penable || (pwrite != lat_wr) || (idx != lat_idx);
            ACCESS:  viol = sel && penable;
            default: viol = 1'b0;
        endcase
    end

    // A malformed access phase is flagged and discarded rather than committed.
    assign xfer_done = (state == SETUP) && !viol;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            prot_err <= 1'b0;
        end else if (viol) begin
            prot_err <= 1'b1;
        end
    end
`else
    assign xfer_done = (state == SETUP) && sel && penable;
    assign prot_err  = 1'b0;
`endif

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            lat_idx <= '0;
            lat_wr  <= 1'b0;
            prdata  <= '0;
        end else if (setup_go) begin
            lat_idx <= idx;
            lat_wr  <= pwrite;
            if (!pwrite) begin
                prdata <= mem[idx];
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (xfer_done && lat_wr) begin
            mem[lat_idx] <= pwdata;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            wr_count <= '0;
            rd_count <= '0;
        end else if (xfer_done) begin
            if (lat_wr) begin
                if (wr_count != 16'hFFFF) begin
                    wr_count <= wr_count + 16'd1;
                end
            end else begin
                if (rd_count != 16'hFFFF) begin
                    rd_count <= rd_count + 16'd1;
                end
            end
        end
    end

endmodule
